decode: RTL and testbench
=========================

# decode

Instruction-decode stage of the rv5stage RV32I pipeline, directly downstream of fetch. Owns the IF/ID pipeline register. It captures fetch's `{pc, inst}` output under `PipeControl` stall/flush, and extracts register indices and sign-extended immediates. It reads the 32×32 integer register file, which has a write-back bypass, and raises a stall request on a load-use hazard.

## Interface
Parameters:
- `RESET_PC`, `32'h80000000`: PC held in IF/ID after reset or flush.
- `NOP_INST`, `32'h00000013`: instruction word held in IF/ID after reset or flush (`addi x0,x0,0`).

Ports:
- `clk`  in  1: single clock, all state updates on posedge.
- `rst`  in  1: reset, synchronous, active-high.
- `pipe`  in  PipeControl: IF/ID register control (`stall`, `flush`).
- `info`  in  FetchInfo: `{pc, inst}` from fetch, valid every cycle fetch is not stalled.
- `req`  out  PipeRequest: `req.stall` = load-use hazard, `req.flush` = 0.
- `ex_mem_read`  in  1: instruction currently in ID/EX is a load.
- `ex_rd`  in  5: destination of that instruction.
- `wb_we`, `wb_rd[4:0]`, `wb_data[31:0]`  in: register-file write port from writeback.
- `id_valid`  out  1: IF/ID holds a real instruction (not a bubble).
- `id_pc`, `id_inst`  out  32: IF/ID contents.
- `rs1`, `rs2`, `rd`  out  5: `inst[19:15]`, `inst[24:20]`, `inst[11:7]`.
- `rs1_data`, `rs2_data`  out  32: register operands, bypassed.
- `imm`  out  32: sign-extended immediate.
- `uses_rs1`, `uses_rs2`  out  1: opcode reads that source.
- `illegal`  out  1: illegal-instruction flag (see Configuration).

## Operation
- IF/ID register update at posedge, priority in this order:
  - `rst` or `pipe.flush`: `id_pc=RESET_PC`, `id_inst=NOP_INST`, `id_valid=0`.
  - `pipe.stall`: hold all contents.
  - otherwise: `id_pc=info.pc`, `id_inst=info.inst`, `id_valid=1`.
- Immediate by opcode:
  - I-type (LOAD, OP-IMM, JALR, SYSTEM): `inst[31:20]`.
  - S-type (STORE): `{inst[31:25],inst[11:7]}`.
  - B-type (BRANCH): `{inst[31],inst[7],inst[30:25],inst[11:8],0}`.
  - U-type (LUI, AUIPC): `{inst[31:12],12'b0}`.
  - J-type (JAL): `{inst[31],inst[19:12],inst[20],inst[30:21],0}`.
  - All other opcodes: `imm=0`.
  - All sign extension is from `inst[31]`.
- Source usage:
  - `uses_rs1` for JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - `uses_rs2` for BRANCH, STORE, OP.
- Register file:
  - Write at posedge when `wb_we && wb_rd!=0`.
  - `x0` reads 0 always.
  - Read bypass: if `wb_we && wb_rd!=0 && wb_rd==rsN`, then `rsN_data=wb_data` in the same cycle.
  - `rst` clears all 31 registers to 0.
- Load-use: `req.stall = id_valid && ex_mem_read && ex_rd!=0 && ((uses_rs1 && ex_rd==rs1) || (uses_rs2 && ex_rd==rs2))`.
  - The controller converts this into `pipe.stall` for PC and IF/ID plus a bubble into ID/EX. This block does not self-stall.
- `rst` during a stall or flush: `rst` wins.
- Flush and stall together: flush wins.

## Timing
- Capture latency: `info` presented in cycle N appears on `id_*` in cycle N+1.
- All decode outputs, operand reads and `req` are combinational from IF/ID state plus the `wb_*`/`ex_*` inputs. No extra cycle.
- Register-file write is visible at the bypass in the same cycle and in the array from the next cycle.
- Reset values after the `rst` posedge:
  - `id_valid=0`, `id_pc=32'h80000000`, `id_inst=32'h13`.
  - `rd=0`, `imm=0`, `uses_rs1=1`, `uses_rs2=0`, `rs*_data=0`.
  - `req.stall=0`, `illegal=0`.

## Configuration
- Macro `RV5STAGE_ILLEGAL_INST_EN`.
- Defined: `illegal = id_valid && (inst[1:0]!=2'b11 || opcode not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM})`.
- Undefined: `illegal` tied to 0. Unknown opcodes pass with `imm=0`, `uses_rs1=uses_rs2=0`.

## Test plan
- Reset then `info={32'h80000004, 32'h00500093}` (addi x1,x0,5), no stall → next cycle `id_valid=1`, `id_pc=32'h80000004`, `rd=1`, `rs1=0`, `imm=5`, `rs1_data=0`.
- Present `info={32'h80000008, 32'hFE000EE3}` (beq x0,x0,-4) → `imm=32'hFFFFFFFC`, `uses_rs2=1`.
- `wb_we=1`, `wb_rd=3`, `wb_data=32'hDEADBEEF`, with IF/ID holding `add x4,x3,x3` → `rs1_data=rs2_data=32'hDEADBEEF` in the same cycle; the value persists after `wb_we` drops.
- `ex_mem_read=1`, `ex_rd=5`, IF/ID holds `add x6,x5,x0` → `req.stall=1`. Repeat with `ex_rd=0` or `ex_rd=7` → `req.stall=0`.
- `pipe.stall=1` for 3 cycles with `info` changing → `id_*` held. Then `pipe.flush=1` together with `pipe.stall=1` → `id_valid=0`, `id_inst=32'h13`, `id_pc=32'h80000000`.
- With `RV5STAGE_ILLEGAL_INST_EN`, `inst=32'h0000007F` → `illegal=1`. Without the macro, the same instruction gives `illegal=0`. A write with `wb_rd=0` never changes the value read from `x0`.

Source files
------------

// File: rtl/decode_if.sv
// rtl/decode_if.sv - pipe control, fetch info and pipe request bundle for the decode stage
interface decode_if;
  logic        pipe_stall;
  logic        pipe_flush;
  logic [31:0] info_pc;
  logic [31:0] info_inst;
  logic        req_stall;
  logic        req_flush;

  modport master (
    output pipe_stall, pipe_flush, info_pc, info_inst,
    input  req_stall, req_flush
  );

  modport slave (
    input  pipe_stall, pipe_flush, info_pc, info_inst,
    output req_stall, req_flush
  );
endinterface

// File: rtl/decode.sv
// rtl/decode.sv - RV32I decode stage: IF/ID register, immediates, bypassed regfile, load-use stall (option: RV5STAGE_ILLEGAL_INST_EN)
module decode #(
  parameter logic [31:0] RESET_PC = 32'h80000000,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  decode_if.slave     bus,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] imm,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        illegal
);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] rf_q [32];
  logic [6:0]  opcode;
  logic        wb_hit;

  // IF/ID next state: flush beats stall, stall holds, otherwise capture fetch
  always_comb begin
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    if (bus.pipe_flush) begin
      id_valid_d = 1'b0;
      id_pc_d    = RESET_PC;
      id_inst_d  = NOP_INST;
    end else if (!bus.pipe_stall) begin
      id_valid_d = 1'b1;
      id_pc_d    = bus.info_pc;
      id_inst_d  = bus.info_inst;
    end
  end

  // IF/ID register; reset loads the same bubble as a flush
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= RESET_PC;
      id_inst_q  <= NOP_INST;
    end else begin
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
    end
  end

  // Register file write port; entry 0 is never written so x0 stays zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
    end else if (wb_hit) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  assign wb_hit   = wb_we && (wb_rd != 5'd0);
  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;
  assign opcode   = id_inst_q[6:0];
  assign rs1      = id_inst_q[19:15];
  assign rs2      = id_inst_q[24:20];
  assign rd       = id_inst_q[11:7];

  // Operand reads with write-back bypass so a same-cycle write is seen immediately
  always_comb begin
    rs1_data = rf_q[rs1];
    rs2_data = rf_q[rs2];
    if (rs1 == 5'd0)              rs1_data = 32'h0;
    else if (wb_hit && wb_rd == rs1) rs1_data = wb_data;
    if (rs2 == 5'd0)              rs2_data = 32'h0;
    else if (wb_hit && wb_rd == rs2) rs2_data = wb_data;
  end

  // Immediate extraction and source-usage flags by opcode
  always_comb begin
    imm      = 32'h0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    unique case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
        imm      = {{20{id_inst_q[31]}}, id_inst_q[31:20]};
        uses_rs1 = 1'b1;
      end
      OPC_SYSTEM: imm = {{20{id_inst_q[31]}}, id_inst_q[31:20]};
      OPC_STORE: begin
        imm      = {{20{id_inst_q[31]}}, id_inst_q[31:25], id_inst_q[11:7]};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        imm      = {{20{id_inst_q[31]}}, id_inst_q[7], id_inst_q[30:25], id_inst_q[11:8], 1'b0};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: imm = {id_inst_q[31:12], 12'h0};
      OPC_JAL: imm = {{12{id_inst_q[31]}}, id_inst_q[19:12], id_inst_q[20], id_inst_q[30:21], 1'b0};
      OPC_OP: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  // Load-use hazard: the load in ID/EX writes a register this instruction reads
  assign bus.req_stall = id_valid_q && ex_mem_read && (ex_rd != 5'd0) &&
                         ((uses_rs1 && ex_rd == rs1) || (uses_rs2 && ex_rd == rs2));
  assign bus.req_flush = 1'b0;

`ifdef RV5STAGE_ILLEGAL_INST_EN
  logic opcode_known;
  assign opcode_known = (opcode == OPC_LUI)    || (opcode == OPC_AUIPC)  ||
                        (opcode == OPC_JAL)    || (opcode == OPC_JALR)   ||
                        (opcode == OPC_BRANCH) || (opcode == OPC_LOAD)   ||
                        (opcode == OPC_STORE)  || (opcode == OPC_OP_IMM) ||
                        (opcode == OPC_OP)     || (opcode == OPC_MISC_MEM) ||
                        (opcode == OPC_SYSTEM);
  assign illegal = id_valid_q && ((id_inst_q[1:0] != 2'b11) || !opcode_known);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_decode.sv
// tb/tb_decode.sv - self-checking bench for decode against a behavioural model
module tb_decode;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        id_valid;
  logic [31:0] id_pc, id_inst;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rs1_data, rs2_data, imm;
  logic        uses_rs1, uses_rs2, illegal;

  decode_if bus ();

  decode dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  bit [31:0] m_rf [32];
  bit        m_valid;
  bit [31:0] m_pc, m_inst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic bit [31:0] sx(input bit [31:0] inst, input bit [31:0] upper);
    return inst[31] ? upper : 32'h0;
  endfunction

  function automatic bit [31:0] exp_imm(input bit [31:0] i);
    case (i & 32'h7f)
      32'h03, 32'h13, 32'h67, 32'h73: return (i >> 20) | sx(i, 32'hFFFFF000);
      32'h23: return (((i >> 25) & 32'h7f) << 5) | ((i >> 7) & 32'h1f) | sx(i, 32'hFFFFF000);
      32'h63: return (((i >> 8) & 32'hf) << 1) | (((i >> 25) & 32'h3f) << 5) |
                     (((i >> 7) & 32'h1) << 11) | sx(i, 32'hFFFFF000);
      32'h37, 32'h17: return i & 32'hFFFFF000;
      32'h6f: return (((i >> 21) & 32'h3ff) << 1) | (((i >> 20) & 32'h1) << 11) |
                     (((i >> 12) & 32'hff) << 12) | sx(i, 32'hFFF00000);
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit exp_u1(input bit [31:0] i);
    int o = int'(i & 32'h7f);
    return o == 'h67 || o == 'h63 || o == 'h03 || o == 'h23 || o == 'h13 || o == 'h33;
  endfunction

  function automatic bit exp_u2(input bit [31:0] i);
    int o = int'(i & 32'h7f);
    return o == 'h63 || o == 'h23 || o == 'h33;
  endfunction

  function automatic bit exp_ill(input bit v, input bit [31:0] i);
`ifdef RV5STAGE_ILLEGAL_INST_EN
    int o = int'(i & 32'h7f);
    bit known = o == 'h37 || o == 'h17 || o == 'h6f || o == 'h67 || o == 'h63 || o == 'h03 ||
                o == 'h23 || o == 'h13 || o == 'h33 || o == 'h0f || o == 'h73;
    return v && ((i & 32'h3) != 32'h3 || !known);
`else
    return 1'b0 & v & i[0];
`endif
  endfunction

  function automatic bit [31:0] exp_rd(input int idx);
    if (idx == 0) return 32'h0;
    if (wb_we && int'(wb_rd) == idx) return wb_data;
    return m_rf[idx];
  endfunction

  task automatic check_all();
    int e_rs1 = int'((m_inst >> 15) & 32'h1f);
    int e_rs2 = int'((m_inst >> 20) & 32'h1f);
    bit e_st = m_valid && ex_mem_read && ex_rd != 0 &&
               ((exp_u1(m_inst) && int'(ex_rd) == e_rs1) || (exp_u2(m_inst) && int'(ex_rd) == e_rs2));
    chk("id_valid", 32'(id_valid), 32'(m_valid));
    chk("id_pc", id_pc, m_pc);
    chk("id_inst", id_inst, m_inst);
    chk("rs1", 32'(rs1), 32'(e_rs1));
    chk("rs2", 32'(rs2), 32'(e_rs2));
    chk("rd", 32'(rd), (m_inst >> 7) & 32'h1f);
    chk("imm", imm, exp_imm(m_inst));
    chk("uses_rs1", 32'(uses_rs1), 32'(exp_u1(m_inst)));
    chk("uses_rs2", 32'(uses_rs2), 32'(exp_u2(m_inst)));
    chk("rs1_data", rs1_data, exp_rd(e_rs1));
    chk("rs2_data", rs2_data, exp_rd(e_rs2));
    chk("req_stall", 32'(bus.req_stall), 32'(e_st));
    chk("req_flush", 32'(bus.req_flush), 32'h0);
    chk("illegal", 32'(illegal), 32'(exp_ill(m_valid, m_inst)));
  endtask

  // Advance one clock: model samples the same inputs the DUT sees, then return to negedge
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_pc = 32'h80000000; m_inst = 32'h13;
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
    end else begin
      if (bus.pipe_flush) begin
        m_valid = 0; m_pc = 32'h80000000; m_inst = 32'h13;
      end else if (!bus.pipe_stall) begin
        m_valid = 1; m_pc = bus.info_pc; m_inst = bus.info_inst;
      end
      if (wb_we && wb_rd != 0) m_rf[wb_rd] = wb_data;
    end
    @(negedge clk);
  endtask

  task automatic present(input logic [31:0] pc, input logic [31:0] inst);
    bus.info_pc = pc;
    bus.info_inst = inst;
  endtask

  bit [31:0] opc_tab [12] = '{32'h37, 32'h17, 32'h6f, 32'h67, 32'h63, 32'h03,
                              32'h23, 32'h13, 32'h33, 32'h0f, 32'h73, 32'h7f};

  initial begin
    rst = 1; ex_mem_read = 0; ex_rd = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
    bus.pipe_stall = 0; bus.pipe_flush = 0;
    present(32'h0, 32'h0);
    @(negedge clk);
    tick();
    tick();
    rst = 0;
    #1;
    check_all();
    chk("reset_pc", id_pc, 32'h80000000);
    chk("reset_inst", id_inst, 32'h13);
    chk("reset_uses_rs1", 32'(uses_rs1), 32'h1);
    chk("reset_imm", imm, 32'h0);

    // addi x1,x0,5
    present(32'h80000004, 32'h00500093);
    tick(); #1;
    check_all();
    chk("addi_imm", imm, 32'h5);
    chk("addi_rd", 32'(rd), 32'h1);

    // beq x0,x0,-4
    present(32'h80000008, 32'hFE000EE3);
    tick(); #1;
    check_all();
    chk("beq_imm", imm, 32'hFFFFFFFC);
    chk("beq_uses_rs2", 32'(uses_rs2), 32'h1);

    // add x4,x3,x3 with same-cycle write-back of x3
    present(32'h8000000C, 32'h00318233);
    tick();
    wb_we = 1; wb_rd = 3; wb_data = 32'hDEADBEEF; #1;
    check_all();
    chk("bypass_rs1", rs1_data, 32'hDEADBEEF);
    chk("bypass_rs2", rs2_data, 32'hDEADBEEF);
    tick();
    wb_we = 0; #1;
    check_all();
    chk("persist_rs1", rs1_data, 32'hDEADBEEF);

    // add x6,x5,x0 against a load to x5 / x0 / x7
    present(32'h80000010, 32'h00028333);
    tick();
    ex_mem_read = 1; ex_rd = 5; #1;
    check_all();
    chk("loaduse_hit", 32'(bus.req_stall), 32'h1);
    ex_rd = 0; #1;
    chk("loaduse_x0", 32'(bus.req_stall), 32'h0);
    ex_rd = 7; #1;
    chk("loaduse_miss", 32'(bus.req_stall), 32'h0);
    ex_mem_read = 0;

    // stall holds while fetch keeps changing
    bus.pipe_stall = 1;
    for (int k = 0; k < 3; k++) begin
      present(32'h90000000 + 32'(k * 4), $urandom);
      tick(); #1;
      check_all();
      chk("stall_hold_pc", id_pc, 32'h80000010);
    end
    bus.pipe_flush = 1;
    tick(); #1;
    check_all();
    chk("flush_valid", 32'(id_valid), 32'h0);
    chk("flush_inst", id_inst, 32'h13);
    chk("flush_pc", id_pc, 32'h80000000);
    bus.pipe_stall = 0; bus.pipe_flush = 0;

    // unknown opcode, and a write to x0
    present(32'h80000020, 32'h0000007F);
    wb_we = 1; wb_rd = 0; wb_data = 32'hFFFFFFFF;
    tick(); #1;
    check_all();
`ifdef RV5STAGE_ILLEGAL_INST_EN
    chk("illegal_7f", 32'(illegal), 32'h1);
`else
    chk("illegal_7f", 32'(illegal), 32'h0);
`endif
    chk("x0_read", rs1_data, 32'h0);
    wb_we = 0;

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      bit [31:0] inst = ($urandom & 32'hFFFFFF80) | opc_tab[$urandom_range(0, 11)];
      if ($urandom_range(0, 1) == 1) inst &= ~((32'h3 << 18) | (32'h3 << 23) | (32'h3 << 10));
      if ($urandom_range(0, 9) == 0) inst = $urandom;
      present($urandom, inst);
      rst = ($urandom_range(0, 59) == 0);
      bus.pipe_stall = ($urandom_range(0, 4) == 0);
      bus.pipe_flush = ($urandom_range(0, 9) == 0);
      wb_we = $urandom_range(0, 1) == 1;
      wb_rd = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      ex_mem_read = $urandom_range(0, 1) == 1;
      ex_rd = 5'($urandom_range(0, 7));
      #1;
      check_all();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
